// File: rtl/serial_transmitter_host.sv
// Serial frame transmitter with optional readback of the remote receiver contents.
// Latency: request accepted on the first rising sclk edge in IDLE; done pulses DATA_LEN*2*CLK_DIV cycles later (CLK_DIV for a clear).
// Backpressure: tx_ready is high only in IDLE; requests seen in any other state are dropped, not queued.
//
// Ports:
//   sclk, reset        system clock, asynchronous active-low reset
//   tx_data/tx_valid   parallel frame and send request; tx_ready marks acceptance
//   clear              request to reset the remote receiver (wins over tx_valid)
//   done               one-cycle pulse when a frame or clear completes
//   ser_clk/ser_data   serial clock and data; the receiver samples on ser_clk falling edge
//   ser_rst_n          active-low reset to the remote receiver
//   sda_in, rx_data    readback serial input and captured frame
// Build option: define SERIAL_READBACK_EN to capture sda_in into rx_data;
// otherwise rx_data is tied to zero and sda_in is ignored.
module serial_transmitter_host #(
    parameter int DATA_LEN = 8,
    parameter int CLK_DIV  = 4
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic                clear,
    output logic                done,
    output logic                ser_clk,
    output logic                ser_data,
    output logic                ser_rst_n,
    input  logic                sda_in,
    output logic [DATA_LEN-1:0] rx_data
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(DATA_LEN + 1);

    // Divider value on the last cycle of the high half and of the whole bit.
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BIT_END   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt, div_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_nxt;
    logic [DATA_LEN-1:0] shreg, shreg_nxt;
    logic                ser_clk_nxt;
    logic                ser_data_nxt;
    logic                ser_rst_n_nxt;

    // Serial outputs are registered together with the state so that
    // nothing combinational reaches ser_clk, ser_data or ser_rst_n.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ser_clk   <= 1'b1;
            ser_data  <= 1'b0;
            ser_rst_n <= 1'b1;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            ser_clk   <= ser_clk_nxt;
            ser_data  <= ser_data_nxt;
            ser_rst_n <= ser_rst_n_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        div_nxt       = div_cnt;
        bit_nxt       = bit_cnt;
        shreg_nxt     = shreg;
        ser_clk_nxt   = ser_clk;
        ser_data_nxt  = ser_data;
        ser_rst_n_nxt = ser_rst_n;

        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt     = CLEAR;
                    ser_rst_n_nxt = 1'b0;
                    div_nxt       = '0;
                end else if (tx_valid) begin
                    // MSB goes out immediately; shreg holds the remaining bits
                    // left-aligned so its MSB is always the next bit to send.
                    state_nxt    = SHIFT;
                    shreg_nxt    = {tx_data[DATA_LEN-2:0], 1'b0};
                    ser_data_nxt = tx_data[DATA_LEN-1];
                    ser_clk_nxt  = 1'b1;
                    div_nxt      = '0;
                    bit_nxt      = '0;
                end
            end

            CLEAR: begin
                if (div_cnt == HALF_LAST) begin
                    ser_rst_n_nxt = 1'b1;
                    div_nxt       = '0;
                    state_nxt     = DONE;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            SHIFT: begin
                if (div_cnt == HALF_LAST) begin
                    ser_clk_nxt = 1'b0;
                end
                if (div_cnt == BIT_END) begin
                    div_nxt     = '0;
                    ser_clk_nxt = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        bit_nxt      = bit_cnt + 1'b1;
                        ser_data_nxt = shreg[DATA_LEN-1];
                        shreg_nxt    = {shreg[DATA_LEN-2:0], 1'b0};
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign tx_ready = (state == IDLE);
    assign done     = (state == DONE);

`ifdef SERIAL_READBACK_EN
    // Sample on the same edge that drops ser_clk: the receiver has not yet
    // shifted, so sda_in still shows its old tip bit. After DATA_LEN
    // captures rx_data holds the receiver contents from before the frame.
    logic capture;
    assign capture = (state == SHIFT) && (div_cnt == HALF_LAST);

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            rx_data <= '0;
        end else if (capture) begin
            rx_data <= {rx_data[DATA_LEN-2:0], sda_in};
        end
    end
`else
    logic unused_sda_in;
    assign unused_sda_in = sda_in;
    assign rx_data       = '0;
`endif

endmodule

// File: tb/tb_serial_transmitter_host.sv
module tb_serial_transmitter_host;

    logic       sclk;
    logic       rst_n;

    // Instance 1: DATA_LEN=8, CLK_DIV=4
    logic [7:0] tx_data1;
    logic       tx_valid1, tx_ready1, clear1, done1;
    logic       ser_clk1, ser_data1, ser_rst_n1, sda_in1;
    logic [7:0] rx_data1;

    // Instance 2: DATA_LEN=2, CLK_DIV=1
    logic [1:0] tx_data2;
    logic       tx_valid2, tx_ready2, clear2, done2;
    logic       ser_clk2, ser_data2, ser_rst_n2, sda_in2;
    logic [1:0] rx_data2;

    int checks   = 0;
    int failures = 0;

    serial_transmitter_host #(.DATA_LEN(8), .CLK_DIV(4)) u_dut1 (
        .sclk(sclk), .reset(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .clear(clear1), .done(done1), .ser_clk(ser_clk1),
        .ser_data(ser_data1), .ser_rst_n(ser_rst_n1), .sda_in(sda_in1), .rx_data(rx_data1)
    );

    serial_transmitter_host #(.DATA_LEN(2), .CLK_DIV(1)) u_dut2 (
        .sclk(sclk), .reset(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .clear(clear2), .done(done2), .ser_clk(ser_clk2),
        .ser_data(ser_data2), .ser_rst_n(ser_rst_n2), .sda_in(sda_in2), .rx_data(rx_data2)
    );

    // Behavioural remote receivers: shift on ser_clk falling edge, tip is MSB.
    logic [7:0] model1 = 8'h00;
    logic [1:0] model2 = 2'b00;
    int         fall_cnt1 = 0;
    int         fall_cnt2 = 0;
    logic       sda_rand_en = 1'b0;
    logic       sda_rand = 1'b0;

    always @(negedge ser_clk1 or negedge ser_rst_n1) begin
        if (!ser_rst_n1) model1 <= 8'h00;
        else             model1 <= {model1[6:0], ser_data1};
    end
    always @(negedge ser_clk1) fall_cnt1 <= fall_cnt1 + 1;

    always @(negedge ser_clk2) begin
        model2    <= {model2[0], ser_data2};
        fall_cnt2 <= fall_cnt2 + 1;
    end

    assign sda_in1 = sda_rand_en ? sda_rand : model1[7];
    assign sda_in2 = model2[1];

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observation window for instance 1, started on the negedge where the
    // request was driven. Sample k is taken after the k-th rising edge
    // counted from the accepting edge.
    int obs_rst_low, obs_done_at, obs_done_cnt, obs_ready_cnt, obs_rx_nz, obs_falls;

    task automatic observe1(input int n, input bit poke_mid, input bit rnd_sda);
        int f0;
        f0            = fall_cnt1;
        obs_rst_low   = 0;
        obs_done_at   = -1;
        obs_done_cnt  = 0;
        obs_ready_cnt = 0;
        obs_rx_nz     = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge sclk);
            if (!ser_rst_n1) obs_rst_low++;
            if (done1) begin
                obs_done_cnt++;
                if (obs_done_at < 0) obs_done_at = k;
            end
            if (tx_ready1) obs_ready_cnt++;
            if (rx_data1 != 8'h00) obs_rx_nz++;
            if (k == 1) begin
                tx_valid1 = 1'b0;
                clear1    = 1'b0;
                tx_data1  = 8'h5A;
            end
            if (poke_mid && k == 10) begin
                tx_valid1 = 1'b1;
                clear1    = 1'b1;
            end
            if (poke_mid && k == 11) begin
                tx_valid1 = 1'b0;
                clear1    = 1'b0;
            end
            sda_rand_en = rnd_sda;
            sda_rand    = 1'($urandom_range(0, 1));
        end
        sda_rand_en = 1'b0;
        obs_falls   = fall_cnt1 - f0;
    endtask

    initial begin
        int d_cnt, d_bad, r_cnt, r_bad, f0;

        rst_n     = 1'b0;
        tx_data1  = 8'h00; tx_valid1 = 1'b0; clear1 = 1'b0;
        tx_data2  = 2'b00; tx_valid2 = 1'b0; clear2 = 1'b0;

        // Reset values
        @(negedge sclk);
        chk("rst_ser_clk",   64'(ser_clk1),   64'(1));
        chk("rst_ser_data",  64'(ser_data1),  64'(0));
        chk("rst_ser_rst_n", 64'(ser_rst_n1), 64'(1));
        chk("rst_done",      64'(done1),      64'(0));
        chk("rst_rx_data",   64'(rx_data1),   64'(0));
        chk("rst_ser_clk2",  64'(ser_clk2),   64'(1));

        // Clear and send in the same cycle, first edge after reset release
        rst_n     = 1'b1;
        clear1    = 1'b1;
        tx_valid1 = 1'b1;
        tx_data1  = 8'hFF;
        observe1(12, 1'b0, 1'b0);
        chk("clr_rst_low_cycles", 64'(obs_rst_low),   64'(4));
        chk("clr_done_at",        64'(obs_done_at),   64'(5));
        chk("clr_done_cnt",       64'(obs_done_cnt),  64'(1));
        chk("clr_ready_cnt",      64'(obs_ready_cnt), 64'(7));
        chk("clr_no_falls",       64'(obs_falls),     64'(0));
        chk("clr_model",          64'(model1),        64'(8'h00));

        // Nominal A5 frame; tx_data altered and requests poked mid-frame
        tx_data1  = 8'hA5;
        tx_valid1 = 1'b1;
        observe1(70, 1'b1, 1'b0);
        chk("a5_done_at",   64'(obs_done_at),   64'(65));
        chk("a5_done_cnt",  64'(obs_done_cnt),  64'(1));
        chk("a5_falls",     64'(obs_falls),     64'(8));
        chk("a5_model",     64'(model1),        64'(8'hA5));
        chk("a5_ready_cnt", 64'(obs_ready_cnt), 64'(5));
        chk("a5_no_clear",  64'(obs_rst_low),   64'(0));
        chk("a5_ser_clk",   64'(ser_clk1),      64'(1));

`ifdef SERIAL_READBACK_EN
        tx_data1  = 8'h3C;
        tx_valid1 = 1'b1;
        observe1(70, 1'b0, 1'b0);
        chk("rb1_done_at", 64'(obs_done_at), 64'(65));
        chk("rb1_rx_data", 64'(rx_data1),    64'(8'hA5));
        chk("rb1_model",   64'(model1),      64'(8'h3C));

        tx_data1  = 8'hC3;
        tx_valid1 = 1'b1;
        observe1(70, 1'b0, 1'b0);
        chk("rb2_rx_data", 64'(rx_data1), 64'(8'h3C));
        chk("rb2_model",   64'(model1),   64'(8'hC3));

        clear1 = 1'b1;
        observe1(12, 1'b0, 1'b0);
        chk("rb_clr_keeps_rx", 64'(rx_data1), 64'(8'h3C));
        chk("rb_clr_model",    64'(model1),   64'(8'h00));
`else
        tx_data1  = 8'h3C;
        tx_valid1 = 1'b1;
        observe1(70, 1'b0, 1'b1);
        chk("norb_rx_nonzero", 64'(obs_rx_nz), 64'(0));
        chk("norb_rx_data",    64'(rx_data1),  64'(0));
        chk("norb_model",      64'(model1),    64'(8'h3C));
`endif

        // Back-to-back frames on the DATA_LEN=2, CLK_DIV=1 instance
        tx_data2  = 2'b01;
        tx_valid2 = 1'b1;
        d_cnt = 0; d_bad = 0; r_cnt = 0; r_bad = 0;
        f0 = fall_cnt2;
        for (int k = 1; k <= 24; k++) begin
            @(negedge sclk);
            if (done2) begin
                d_cnt++;
                if (k % 6 != 5) d_bad++;
            end
            if (tx_ready2) begin
                r_cnt++;
                if (k % 6 != 0) r_bad++;
            end
        end
        tx_valid2 = 1'b0;
        chk("b2b_done_cnt",  64'(d_cnt),               64'(4));
        chk("b2b_done_slot", 64'(d_bad),               64'(0));
        chk("b2b_ready_cnt", 64'(r_cnt),               64'(4));
        chk("b2b_ready_slot",64'(r_bad),               64'(0));
        chk("b2b_falls",     64'(fall_cnt2 - f0),      64'(8));
        chk("b2b_model",     64'(model2),              64'(2'b01));
        chk("b2b_ser_clk",   64'(ser_clk2),            64'(1));
`ifdef SERIAL_READBACK_EN
        chk("b2b_rx_data",   64'(rx_data2),            64'(2'b01));
`endif
        repeat (3) @(negedge sclk);
        chk("b2b_idle_ready", 64'(tx_ready2), 64'(1));

        // Reset mid-frame at cycle 20 of an A5 frame
        tx_data1  = 8'hA5;
        tx_valid1 = 1'b1;
        @(negedge sclk);
        tx_valid1 = 1'b0;
        repeat (19) @(negedge sclk);
        chk("mid_pre_ser_data", 64'(ser_data1), 64'(1));
        chk("mid_pre_ready",    64'(tx_ready1), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_ser_clk",   64'(ser_clk1),   64'(1));
        chk("mid_ser_data",  64'(ser_data1),  64'(0));
        chk("mid_ser_rst_n", 64'(ser_rst_n1), 64'(1));
        chk("mid_done",      64'(done1),      64'(0));
        chk("mid_rx_data",   64'(rx_data1),   64'(0));
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        observe1(80, 1'b0, 1'b0);
        chk("mid_no_done",   64'(obs_done_cnt),  64'(0));
        chk("mid_ready_cnt", 64'(obs_ready_cnt), 64'(80));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_transmitter_host.md
SERIAL_TRANSMITTER_HOST -- requirements
Module: serial_transmitter_host

Interface
REQ-001 Parameter DATA_LEN, default 8, frame length in bits; legal range 2..512.
REQ-002 Parameter CLK_DIV, default 4, serial clock half-period in sclk cycles; legal range 1..256.
REQ-003 sclk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  DATA_LEN  parallel frame to send.
REQ-006 tx_valid  input  1  frame-send request.
REQ-007 tx_ready  output  1  high when a request can be accepted.
REQ-008 clear  input  1  request to clear the remote receiver.
REQ-009 done  output  1  one-cycle pulse when a frame or clear completes.
REQ-010 ser_clk  output  1  serial clock to the remote receiver; the receiver samples on its falling edge.
REQ-011 ser_data  output  1  serial data to the remote receiver.
REQ-012 ser_rst_n  output  1  active-low reset to the remote receiver.
REQ-013 sda_in  input  1  serial data returned from the remote receiver tip.
REQ-014 rx_data  output  DATA_LEN  captured readback frame.

Function
REQ-015 The block SHALL implement states IDLE, CLEAR, SHIFT and DONE.
REQ-016 tx_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, clear=1 SHALL enter CLEAR, and clear SHALL take priority over tx_valid.
REQ-018 In IDLE with clear=0, tx_valid=1 SHALL latch tx_data and enter SHIFT.
REQ-019 CLEAR SHALL drive ser_rst_n=0 for exactly CLK_DIV cycles, then go to DONE.
REQ-020 SHIFT SHALL send bits MSB first, so that after the frame the remote receiver holds tx_data.
REQ-021 Each bit SHALL last 2*CLK_DIV cycles: ser_data is updated and ser_clk=1 at bit start, ser_clk=1 for CLK_DIV cycles, then ser_clk=0 for CLK_DIV cycles.
REQ-022 A frame in SHIFT SHALL occupy exactly DATA_LEN*2*CLK_DIV cycles.
REQ-023 After the last bit, ser_clk SHALL return to 1 and the FSM SHALL enter DONE for one cycle, with done=1.
REQ-024 DONE SHALL always return to IDLE.
REQ-025 clear and tx_valid outside IDLE SHALL be ignored and not queued; tx_data changes after acceptance SHALL have no effect.
REQ-026 The divider counter SHALL be ceil(log2(2*CLK_DIV)) bits and the bit counter ceil(log2(DATA_LEN+1)) bits; both SHALL wrap to 0 at the end of each bit and frame respectively.
REQ-027 ser_clk, ser_data and ser_rst_n SHALL be driven directly from flops, with no combinational path to the outputs.

Reset
REQ-028 reset=0 SHALL asynchronously force: state=IDLE, ser_clk=1, ser_data=0, ser_rst_n=1, done=0, tx_ready=1 (after deassertion), rx_data=0, and all counters=0.
REQ-029 Assertion of reset mid-frame SHALL abort the frame with no done pulse.
REQ-030 The first request after reset deassertion SHALL be accepted on the first rising sclk edge.

Configuration
REQ-031 Macro SERIAL_READBACK_EN SHALL control the readback feature.
REQ-032 With SERIAL_READBACK_EN defined: on each sclk edge that drives ser_clk from 1 to 0 in SHIFT, sda_in SHALL be shifted into rx_data LSB-first-in, so that at done rx_data equals the remote receiver contents before the frame.
REQ-033 With SERIAL_READBACK_EN defined: rx_data SHALL hold its value until the next frame; a CLEAR sequence SHALL not alter rx_data.
REQ-034 Without SERIAL_READBACK_EN: rx_data SHALL be constant 0, sda_in SHALL be unused, and no capture flops SHALL be inferred.

Verification
REQ-035 Reset mid-frame: DATA_LEN=8, CLK_DIV=4, tx_data=8'hA5 accepted, reset asserted at cycle 20 -> outputs take reset values immediately, no done pulse, tx_ready=1 after release.
REQ-036 Nominal frame: tx_data=8'hA5 with a behavioural negedge receiver model -> done asserted 64 cycles after acceptance, model holds 8'hA5, 8 ser_clk falling edges observed.
REQ-037 Readback (macro defined): frame 8'h3C followed by frame 8'hC3 -> rx_data=8'h3C after the second done.
REQ-038 Clear vs send: clear=1 and tx_valid=1 in the same IDLE cycle -> ser_rst_n=0 for 4 cycles, then done, model holds 0, tx_data not sent.
REQ-039 Back-to-back and boundary: tx_valid held high, CLK_DIV=1, DATA_LEN=2 -> frames every 6 cycles (4 SHIFT + DONE + IDLE), tx_ready low in between, requests during SHIFT ignored.
REQ-040 Macro undefined: toggle sda_in randomly through a frame -> rx_data stays 0.
